serial_compare_ctrl: RTL and testbench

Sequential magnitude-comparison controller that compares two WIDTH-bit unsigned operands by stepping one shared 2-bit `greater_than` slice pair over them, MSB slice first, one slice per clock. It sits between a requester issuing start/operand pairs and the existing 2-bit `greater_than` comparator datapath. It sequences that datapath, terminates early on the first differing slice, and reports a registered gt/eq/lt verdict with a start/busy/done handshake.

---
 rtl/serial_compare_ctrl.sv | 140 ++++++++++++++
 tb/tb_serial_compare_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
//   Sequential unsigned magnitude comparator. Steps a 2-bit greater_than
//   slice pair over two WIDTH-bit operands, MSB slice first, one slice per
//   clock. It stops at the first differing slice and reports a registered
//   gt/eq/lt verdict.
//
// Parameters
//   WIDTH  operand width in bits; must be even and >= 2
//
// Ports
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   start  request pulse, accepted when not busy (IDLE or DONE)
//   a, b   unsigned operands, captured on start acceptance
//   busy   comparison in progress
//   done   one-cycle pulse, verdict valid
//   gt     A > B
//   eq     A == B
//   lt     A < B

module serial_compare_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
            $error("serial_compare_ctrl: WIDTH must be even and at least 2");
        end
    endgenerate

    localparam int unsigned CW = $clog2(WIDTH / 2) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // 2-bit greater_than slice comparator of the shared datapath.
    function automatic logic greater_than(input logic [1:0] x, input logic [1:0] y);
        return x > y;
    endfunction

    state_t          state, state_n;
    logic [WIDTH-1:0] sa, sa_n;
    logic [WIDTH-1:0] sb, sb_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             gt_n, eq_n, lt_n;
    logic             busy_n, done_n;
    logic             slice_gt, slice_lt;

    // Two comparator uses on the current top slice; equal when neither fires.
    assign slice_gt = greater_than(sa[WIDTH-1 -: 2], sb[WIDTH-1 -: 2]);
    assign slice_lt = greater_than(sb[WIDTH-1 -: 2], sa[WIDTH-1 -: 2]);

    always_comb begin
        state_n = state;
        sa_n    = sa;
        sb_n    = sb;
        cnt_n   = cnt;
        gt_n    = gt;
        eq_n    = eq;
        lt_n    = lt;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    sa_n    = a;
                    sb_n    = b;
                    cnt_n   = CW'(WIDTH / 2 - 1);
                    gt_n    = 1'b0;
                    eq_n    = 1'b0;
                    lt_n    = 1'b0;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (slice_gt) begin
                    gt_n    = 1'b1;
                    state_n = DONE;
                end else if (slice_lt) begin
                    lt_n    = 1'b1;
                    state_n = DONE;
                end else if (cnt == '0) begin
                    // Last slice compared equal: operands equal; cnt never wraps.
                    eq_n    = 1'b1;
                    state_n = DONE;
                end else begin
                    sa_n  = sa << 2;
                    sb_n  = sb << 2;
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // busy/done are flopped from the next state so they come straight
        // out of registers.
        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sa    <= sa_n;
            sb    <= sb_n;
            cnt   <= cnt_n;
            gt    <= gt_n;
            eq    <= eq_n;
            lt    <= lt_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: a WIDTH=2 instance swept over all
// operand pairs and a WIDTH=8 instance run through directed scenarios.
// Observations are packed as {busy, done, gt, eq, lt}.

module tb_serial_compare_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       start2;
    logic [1:0] a2, b2;
    logic       busy2, done2, gt2, eq2, lt2;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, gt8, eq8, lt8;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .busy  (busy2),
        .done  (done2),
        .gt    (gt2),
        .eq    (eq2),
        .lt    (lt2)
    );

    serial_compare_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .gt    (gt8),
        .eq    (eq8),
        .lt    (lt8)
    );

    wire [4:0] obs2 = {busy2, done2, gt2, eq2, lt2};
    wire [4:0] obs8 = {busy8, done8, gt8, eq8, lt8};

    task automatic chk(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed {busy,done,gt,eq,lt}=%b expected %b", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a WIDTH=8 comparison deciding at edge E0+k with the given flags.
    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input int k, input logic [2:0] flags);
        a8     = av;
        b8     = bv;
        start8 = 1'b1;
        tick();
        chk({tag, "_accept"}, obs8, 5'b10000);
        start8 = 1'b0;
        for (int j = 1; j < k; j++) begin
            tick();
            chk({tag, "_busy"}, obs8, 5'b10000);
        end
        tick();
        chk({tag, "_done"}, obs8, {2'b01, flags});
        tick();
        chk({tag, "_hold"}, obs8, {2'b00, flags});
    endtask

    initial begin
        logic [3:0] v;
        logic [2:0] f;

        rst    = 1'b1;
        start2 = 1'b0;
        start8 = 1'b0;
        a2     = '0;
        b2     = '0;
        a8     = '0;
        b8     = '0;
        #2;
        chk("reset_w2", obs2, 5'b00000);
        chk("reset_w8", obs8, 5'b00000);
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        chk("idle_w8", obs8, 5'b00000);

        // WIDTH=2 exhaustive: single slice, always decides one edge after start.
        for (int i = 0; i < 16; i++) begin
            v      = 4'(i);
            a2     = v[3:2];
            b2     = v[1:0];
            f      = {a2 > b2, a2 == b2, a2 < b2};
            start2 = 1'b1;
            tick();
            chk("w2_accept", obs2, 5'b10000);
            start2 = 1'b0;
            tick();
            chk("w2_done", obs2, {2'b01, f});
            tick();
            chk("w2_hold", obs2, {2'b00, f});
        end

        // MSB slice 3 vs 1 decides on the first edge.
        run8("c3_43", 8'hC3, 8'h43, 1, 3'b100);
        // Slices equal until the last (2 vs 3).
        run8("12_13", 8'h12, 8'h13, 4, 3'b001);
        // All slices equal: full length.
        run8("a5_a5", 8'hA5, 8'hA5, 4, 3'b010);
        // Differ in second slice (0xB0 vs 0x90: 2/2 then 3 vs 1).
        run8("b0_90", 8'hB0, 8'h90, 2, 3'b100);

        // Back-to-back: start held, a changed mid-flight, second start
        // accepted in the DONE cycle with the new operands.
        a8     = 8'h40;
        b8     = 8'h80;
        start8 = 1'b1;
        tick();
        chk("b2b_accept", obs8, 5'b10000);
        a8 = 8'hFF;
        tick();
        chk("b2b_first_done", obs8, 5'b01001);
        tick();
        chk("b2b_second_accept", obs8, 5'b10000);
        start8 = 1'b0;
        tick();
        chk("b2b_second_done", obs8, 5'b01100);
        tick();
        chk("b2b_hold", obs8, 5'b00100);

        // Asynchronous reset mid-RUN aborts without a done pulse.
        a8     = 8'h01;
        b8     = 8'h02;
        start8 = 1'b1;
        tick();
        chk("rst_accept", obs8, 5'b10000);
        start8 = 1'b0;
        tick();
        chk("rst_busy", obs8, 5'b10000);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", obs8, 5'b00000);
        #3;
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("rst_no_done", obs8, 5'b00000);
        end
        run8("after_rst", 8'h01, 8'h02, 4, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
